exfil_tx_fifo: RTL and testbench

- Downstream consumer of the target ROM bus in RUN mode. Captures low address bytes of target reads that fall inside the 256-byte exfiltration window.
- Buffers the captured bytes in a small FIFO and writes them to the FT240X transmit FIFO with correct WR#/TXE timing.
- Replaces the combinational WR# gating in the top level. Shares the FT240X data bus with the command reader, arbitrated by rx_busy/tx_busy.

---
 rtl/exfil_tx_fifo_if.sv | 41 ++++
 rtl/exfil_tx_fifo.sv | 195 +++++++++++++++++++
 tb/tb_exfil_tx_fifo.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exfil_tx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : exfil_tx_fifo_if
//  Description : FT240X transmit-side bus bundle shared between the
//                exfiltration transmitter and the top level / command reader.
//  Signals     : rx_busy   - command reader owns the FT240X bus
//                ft_TXE    - FT240X TX FIFO full (high = do not write)
//                ft_d_out  - byte to drive onto ft240x_d
//                ft_d_oe   - top level drives ft240x_d from ft_d_out
//                ft_nWR    - FT240X write strobe, active low
//                tx_busy   - transmitter owns the FT240X bus
//  Modports    : master = transmitter side, slave = top level / reader side
//  Revision    : 1.0  initial release
// ============================================================================
interface exfil_tx_fifo_if;
    logic       rx_busy;
    logic       ft_TXE;
    logic [7:0] ft_d_out;
    logic       ft_d_oe;
    logic       ft_nWR;
    logic       tx_busy;

    modport master (
        input  rx_busy,
        input  ft_TXE,
        output ft_d_out,
        output ft_d_oe,
        output ft_nWR,
        output tx_busy
    );

    modport slave (
        output rx_busy,
        output ft_TXE,
        input  ft_d_out,
        input  ft_d_oe,
        input  ft_nWR,
        input  tx_busy
    );
endinterface
`default_nettype wire

// File: rtl/exfil_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : exfil_tx_fifo
//  Description : Captures the low address byte of target ROM reads that hit
//                the 256-byte exfiltration window, buffers them in a small
//                FIFO and writes them to the FT240X with WR#/TXE timing
//                (SETUP -> STROBE x WR_PULSE -> HOLD -> IDLE turnaround).
//  Ports       : clk24MHz, reset (sync, active high)
//                enable       - exfiltration enabled
//                exfil_addr   - window select vs addr_bus[17:8]
//                addr_bus     - target address bus (async)
//                tgt_nCE/tgt_nOEL/tgt_nOEH - target strobes (async, low)
//                ft           - exfil_tx_fifo_if.master FT240X bundle
//                overflow     - sticky: a capture was dropped
//                drop_count   - saturating count of dropped captures
//  Parameters  : DEPTH_LOG2 (FIFO depth = 2**DEPTH_LOG2), WR_PULSE (1..7)
//  Options     : EXFIL_DEDUP_EN - suppress captures equal to the last
//                pushed byte
//  Revision    : 1.0  initial release
// ============================================================================
module exfil_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WR_PULSE   = 2
) (
    input  wire logic        clk24MHz,
    input  wire logic        reset,
    input  wire logic        enable,
    input  wire logic [9:0]  exfil_addr,
    input  wire logic [17:0] addr_bus,
    input  wire logic        tgt_nCE,
    input  wire logic        tgt_nOEL,
    input  wire logic        tgt_nOEH,
    exfil_tx_fifo_if.master  ft,
    output logic             overflow,
    output logic [7:0]       drop_count
);

    localparam int         c_depth      = 1 << DEPTH_LOG2;
    localparam logic [2:0] c_pulse_last = 3'(WR_PULSE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    // ---------------- access detect ----------------
    logic w_access;
    logic r_sync1, r_sync2, r_sync3;
    logic w_strobe;

    assign w_access = !tgt_nCE && (!tgt_nOEL || !tgt_nOEH);

    always_ff @(posedge clk24MHz) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= w_access;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Rising edge of the synchronised access; addr_bus has been stable for
    // at least two cycles by now, so sampling it directly is safe.
    assign w_strobe = r_sync2 && !r_sync3;

    // ---------------- capture qualification ----------------
    logic       w_match;
    logic [7:0] w_byte;
    logic       w_dup;
    logic       w_capture;

    assign w_match = w_strobe && enable && (addr_bus[17:8] == exfil_addr);
    assign w_byte  = addr_bus[7:0];

    // ---------------- FIFO ----------------
    logic [DEPTH_LOG2:0] r_wr_ptr, r_rd_ptr;
    logic [7:0]          r_mem [c_depth];
    logic                w_full, w_empty;
    logic                w_push, w_pop, w_drop;
    state_t              r_state, w_next;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                     (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);

    assign w_pop     = (r_state == S_HOLD);
    assign w_capture = w_match && !w_dup;
    // A simultaneous pop frees a slot, so a push into a full FIFO still fits.
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && w_full && !w_pop;

`ifdef EXFIL_DEDUP_EN
    logic       r_last_valid;
    logic [7:0] r_last_byte;

    assign w_dup = r_last_valid && (r_last_byte == w_byte);

    // Invalidated while disabled so the first capture after enabling is kept.
    always_ff @(posedge clk24MHz) begin
        if (reset || !enable) begin
            r_last_valid <= 1'b0;
            r_last_byte  <= 8'h00;
        end else if (w_push) begin
            r_last_valid <= 1'b1;
            r_last_byte  <= w_byte;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    always_ff @(posedge clk24MHz) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            overflow   <= 1'b0;
            drop_count <= 8'h00;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF)
                    drop_count <= drop_count + 8'h01;
            end
        end
    end

    // Storage is not reset; the pointers alone define the contents.
    always_ff @(posedge clk24MHz) begin
        if (!reset && w_push)
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= w_byte;
    end

    // ---------------- TX FSM ----------------
    logic [2:0] r_pulse_cnt;
    logic       r_nwr;
    logic       r_bus_own;
    logic [7:0] r_d_out;

    always_ff @(posedge clk24MHz) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // TXE and rx_busy are only consulted in IDLE; a started write completes.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (!w_empty && !ft.ft_TXE && !ft.rx_busy) w_next = S_SETUP;
            S_SETUP:  w_next = S_STROBE;
            S_STROBE: if (r_pulse_cnt == c_pulse_last) w_next = S_HOLD;
            S_HOLD:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk24MHz) begin
        if (reset || r_state != S_STROBE)
            r_pulse_cnt <= 3'd0;
        else
            r_pulse_cnt <= r_pulse_cnt + 3'd1;
    end

    // Outputs are registered from the next state so WR# and OE are
    // glitch-free and change together with the state register.
    always_ff @(posedge clk24MHz) begin
        if (reset) begin
            r_nwr     <= 1'b1;
            r_bus_own <= 1'b0;
            r_d_out   <= 8'h00;
        end else begin
            r_nwr     <= (w_next != S_STROBE);
            r_bus_own <= (w_next != S_IDLE);
            if (r_state == S_IDLE && w_next == S_SETUP)
                r_d_out <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
        end
    end

    assign ft.ft_nWR    = r_nwr;
    assign ft.ft_d_oe   = r_bus_own;
    assign ft.tx_busy   = r_bus_own;
    assign ft.ft_d_out  = r_d_out;

endmodule
`default_nettype wire

// File: tb/tb_exfil_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exfil_tx_fifo
//  Description : Self-checking bench for exfil_tx_fifo. A queue model of the
//                capture FIFO plus a protocol tracker check every FT240X
//                write; directed tests pin the model with literal values.
//  Options     : EXFIL_DEDUP_EN (must match the RTL build)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_exfil_tx_fifo;
    localparam int DL  = 4;
    localparam int WP  = 2;
    localparam int CAP = 1 << DL;
`ifdef EXFIL_DEDUP_EN
    localparam int DEDUP_WRITES = 2;
`else
    localparam int DEDUP_WRITES = 3;
`endif

    logic        clk24MHz = 1'b0;
    logic        reset    = 1'b1;
    logic        enable   = 1'b0;
    logic [9:0]  exfil_addr = 10'h000;
    logic [17:0] addr_bus = 18'h0;
    logic        tgt_nCE  = 1'b1;
    logic        tgt_nOEL = 1'b1;
    logic        tgt_nOEH = 1'b1;
    logic        overflow;
    logic [7:0]  drop_count;

    exfil_tx_fifo_if ft_if ();

    exfil_tx_fifo #(.DEPTH_LOG2(DL), .WR_PULSE(WP)) dut (
        .clk24MHz   (clk24MHz),
        .reset      (reset),
        .enable     (enable),
        .exfil_addr (exfil_addr),
        .addr_bus   (addr_bus),
        .tgt_nCE    (tgt_nCE),
        .tgt_nOEL   (tgt_nOEL),
        .tgt_nOEH   (tgt_nOEH),
        .ft         (ft_if),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #20 clk24MHz = ~clk24MHz;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [7:0] model_q [$];
    logic [7:0] written [$];
    int         model_drops = 0;
    bit         model_ovf   = 1'b0;
    bit         model_last_valid = 1'b0;
    logic [7:0] model_last = 8'h00;
    bit         settling = 1'b0;

    task automatic model_capture(input logic [17:0] a);
        bit dup;
        dup = 1'b0;
`ifdef EXFIL_DEDUP_EN
        dup = model_last_valid && (model_last == a[7:0]);
`endif
        if (enable && a[17:8] == exfil_addr && !dup) begin
            if (model_q.size() < CAP) begin
                model_q.push_back(a[7:0]);
                model_last_valid = 1'b1;
                model_last       = a[7:0];
            end else begin
                model_ovf = 1'b1;
                if (model_drops < 255) model_drops++;
            end
        end
    endtask

    // ---------------- compare process ----------------
    // phase: 0 idle, 1 setup seen, 2 strobe, 3 hold seen
    int         phase = 0;
    int         run   = 0;
    logic [7:0] cur   = 8'h00;

    always @(negedge clk24MHz) begin
        if (reset) begin
            phase = 0;
            run   = 0;
        end else begin
            chk("busy_eq_oe", ft_if.tx_busy, ft_if.ft_d_oe);
            if (!settling) begin
                chk("overflow", overflow, model_ovf);
                chk("drop_count", drop_count, model_drops);
            end
            case (phase)
                0: begin
                    if (ft_if.ft_d_oe) begin
                        chk("setup_nwr", ft_if.ft_nWR, 1);
                        chk("setup_q_nonempty", model_q.size() != 0, 1);
                        if (model_q.size() != 0)
                            chk("setup_data", ft_if.ft_d_out, model_q[0]);
                        cur   = ft_if.ft_d_out;
                        phase = 1;
                    end else begin
                        chk("idle_nwr", ft_if.ft_nWR, 1);
                    end
                end
                1: begin
                    chk("strobe_start_nwr", ft_if.ft_nWR, 0);
                    chk("strobe_oe", ft_if.ft_d_oe, 1);
                    chk("strobe_data", ft_if.ft_d_out, cur);
                    run   = 1;
                    phase = 2;
                end
                2: begin
                    chk("strobe_oe", ft_if.ft_d_oe, 1);
                    chk("strobe_data", ft_if.ft_d_out, cur);
                    if (!ft_if.ft_nWR) begin
                        run++;
                    end else begin
                        chk("pulse_len", run, WP);
                        written.push_back(cur);
                        if (model_q.size() != 0) void'(model_q.pop_front());
                        phase = 3;
                    end
                end
                default: begin
                    chk("turnaround_oe", ft_if.ft_d_oe, 0);
                    chk("turnaround_nwr", ft_if.ft_nWR, 1);
                    phase = 0;
                end
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk24MHz);
        #2;
    endtask

    task automatic do_read(input logic [17:0] a);
        tick();
        settling = 1'b1;
        addr_bus = a;
        tgt_nCE  = 1'b0;
        tgt_nOEL = 1'b0;
        model_capture(a);
        repeat (6) tick();
        tgt_nCE  = 1'b1;
        tgt_nOEL = 1'b1;
        repeat (3) tick();
        settling = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((model_q.size() != 0 || ft_if.tx_busy) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_in_time", n < budget, 1);
        repeat (3) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int base;
        int lat;
        ft_if.rx_busy = 1'b0;
        ft_if.ft_TXE  = 1'b0;

        repeat (4) tick();
        chk("rst_nwr", ft_if.ft_nWR, 1);
        chk("rst_oe", ft_if.ft_d_oe, 0);
        chk("rst_dout", ft_if.ft_d_out, 8'h00);
        chk("rst_busy", ft_if.tx_busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_count, 0);
        reset      = 1'b0;
        exfil_addr = 10'h3C0;
        enable     = 1'b1;
        repeat (2) tick();

        // Two matching reads; first one also measures access-to-WR# latency
        base = written.size();
        tick();
        settling = 1'b1;
        addr_bus = 18'h3C012;
        tgt_nCE  = 1'b0;
        tgt_nOEL = 1'b0;
        model_capture(18'h3C012);
        lat = 0;
        while (ft_if.ft_nWR && lat < 20) begin
            @(posedge clk24MHz);
            #1;
            lat++;
        end
        chk("latency_edges", lat, 5);
        #1;
        tgt_nCE  = 1'b1;
        tgt_nOEL = 1'b1;
        repeat (3) tick();
        settling = 1'b0;
        do_read(18'h3C0A5);
        wait_idle(100);
        chk("two_writes", written.size() - base, 2);
        if (written.size() >= base + 2) begin
            chk("byte0_12", written[base], 8'h12);
            chk("byte1_A5", written[base+1], 8'hA5);
        end

        // Outside window
        base = written.size();
        do_read(18'h3C112);
        repeat (10) tick();
        chk("nomatch_no_write", written.size() - base, 0);
        chk("nomatch_nwr", ft_if.ft_nWR, 1);

        // Disabled: no capture (uses nOEH this time)
        enable = 1'b0;
        model_last_valid = 1'b0;
        base = written.size();
        tick();
        settling = 1'b1;
        addr_bus = 18'h3C033;
        tgt_nCE  = 1'b0;
        tgt_nOEH = 1'b0;
        model_capture(18'h3C033);
        repeat (6) tick();
        tgt_nCE  = 1'b1;
        tgt_nOEH = 1'b1;
        repeat (3) tick();
        settling = 1'b0;
        repeat (10) tick();
        chk("disabled_no_write", written.size() - base, 0);
        enable = 1'b1;

        // Fill past capacity with TXE high
        ft_if.ft_TXE = 1'b1;
        base = written.size();
        for (int i = 0; i < 18; i++)
            do_read({10'h3C0, 8'(i)});
        chk("txe_blocks", written.size() - base, 0);
        chk("ovf_lit", overflow, 1);
        chk("drop_lit", drop_count, 2);
        ft_if.ft_TXE = 1'b0;
        wait_idle(400);
        chk("drain16", written.size() - base, 16);
        for (int k = 0; k < 16; k++)
            if (written.size() > base + k)
                chk("drain_order", written[base+k], k);

        // rx_busy holds off SETUP; release gives SETUP next cycle
        ft_if.rx_busy = 1'b1;
        do_read(18'h3C077);
        repeat (4) tick();
        chk("rxbusy_no_oe", ft_if.ft_d_oe, 0);
        chk("rxbusy_no_busy", ft_if.tx_busy, 0);
        ft_if.rx_busy = 1'b0;
        @(posedge clk24MHz);
        #1;
        chk("rxfree_setup_oe", ft_if.ft_d_oe, 1);
        chk("rxfree_setup_nwr", ft_if.ft_nWR, 1);
        chk("rxfree_setup_data", ft_if.ft_d_out, 8'h77);
        wait_idle(100);

        // Repeated byte
        base = written.size();
        do_read(18'h3C055);
        do_read(18'h3C055);
        do_read(18'h3C056);
        wait_idle(200);
        chk("dedup_writes", written.size() - base, DEDUP_WRITES);
        if (written.size() >= base + DEDUP_WRITES)
            chk("dedup_last", written[base+DEDUP_WRITES-1], 8'h56);

        // Reset during STROBE
        tick();
        settling = 1'b1;
        addr_bus = 18'h3C0EE;
        tgt_nCE  = 1'b0;
        tgt_nOEL = 1'b0;
        model_capture(18'h3C0EE);
        lat = 0;
        do begin
            @(negedge clk24MHz);
            lat++;
        end while (ft_if.ft_nWR && lat < 30);
        chk("reached_strobe", ft_if.ft_nWR, 0);
        #1;
        reset    = 1'b1;
        tgt_nCE  = 1'b1;
        tgt_nOEL = 1'b1;
        model_q.delete();
        model_drops = 0;
        model_ovf   = 1'b0;
        model_last_valid = 1'b0;
        base = written.size();
        @(posedge clk24MHz);
        #1;
        chk("rstw_nwr", ft_if.ft_nWR, 1);
        chk("rstw_oe", ft_if.ft_d_oe, 0);
        chk("rstw_busy", ft_if.tx_busy, 0);
        chk("rstw_ovf", overflow, 0);
        chk("rstw_drop", drop_count, 0);
        tick();
        reset    = 1'b0;
        settling = 1'b0;
        repeat (20) tick();
        chk("rstw_no_write", written.size() - base, 0);
        chk("rstw_idle_oe", ft_if.ft_d_oe, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
